line_upsampler: RTL

LINE_UPSAMPLER -- requirements
Module: line_upsampler

---
 rtl/line_upsampler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/line_upsampler.sv
// Nearest-neighbour line upsampler: each input pixel is repeated S times across
// and each input row S times down (S = 1, 2 or 4), using one line buffer for the replays.
module line_upsampler #(
  parameter int DATA_W = 8,
  parameter int IN_W   = 400,
  parameter int IN_H   = 300,
  parameter int CNT_W  = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        scale_sel,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_row,
  output logic [CNT_W-1:0]  out_col,
  output logic              out_sof,
  output logic              out_eol,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // out_* stays frozen while out_valid && !out_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, REPEAT = 2'd2} state_t;

  localparam int AW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] IN_W_C   = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(IN_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IN_H - 1);

  state_t            state;
  logic [1:0]        sh;       // log2 of the latched scale factor
  logic [1:0]        hcnt;     // replicas still to send after the one on out_data
  logic [1:0]        vrep;     // which vertical copy of the input row is being sent
  logic [CNT_W-1:0]  in_col;   // pixels accepted in the current input row
  logic [CNT_W-1:0]  in_row;
  logic [CNT_W-1:0]  rep_col;  // buffer entries already loaded in this replayed row
  logic [DATA_W-1:0] line_buf [IN_W];
  logic [DATA_W-1:0] pf_data;  // prefetched buffer entry for the next replay load

  logic [CNT_W-1:0]  last_col, last_orow, wr_col, rd_addr;
  logic [1:0]        s_m1;
  logic              xfer, free, row_end, copies_done, last_in_row, next_fill;
  logic              load_in, load_rep, do_fetch;

  always_comb begin
    last_col  = CNT_W'(IN_W - 1);
    last_orow = CNT_W'(IN_H - 1);
    s_m1      = 2'd0;
    case (sh)
      2'd1: begin
        last_col  = CNT_W'(2 * IN_W - 1);
        last_orow = CNT_W'(2 * IN_H - 1);
        s_m1      = 2'd1;
      end
      2'd2: begin
        last_col  = CNT_W'(4 * IN_W - 1);
        last_orow = CNT_W'(4 * IN_H - 1);
        s_m1      = 2'd3;
      end
      default: ;
    endcase
  end

  assign xfer        = out_valid && out_ready;
  assign free        = !out_valid || out_ready;
  assign row_end     = xfer && (out_col == last_col);
  assign copies_done = (vrep == s_m1);
  assign last_in_row = (in_row == LAST_ROW);
  assign next_fill   = row_end && copies_done && !last_in_row;

  // At 1x the next row may start in the very cycle the previous row's last pixel leaves.
  assign in_ready = (state == FILL) && (hcnt == 2'd0) && free &&
                    ((in_col != IN_W_C) || next_fill);
  assign load_in  = in_valid && in_ready;
  assign wr_col   = (in_col == IN_W_C) ? '0 : in_col;

  assign load_rep = (state == REPEAT) && (hcnt == 2'd0) && free && (rep_col != IN_W_C);
  assign do_fetch = (row_end && !copies_done) || (load_rep && (rep_col != LAST_IN));
  assign rd_addr  = row_end ? '0 : rep_col + 1'b1;

  assign busy      = (state != IDLE);
  assign fsm_state = state;
  assign out_sof   = out_valid && (out_row == '0) && (out_col == '0);
  assign out_eol   = out_valid && (out_col == last_col);

  // Line buffer: written while filling, read one cycle ahead of each replay load.
  always_ff @(posedge clock) begin
    if (load_in) line_buf[wr_col[AW-1:0]] <= in_data;
    if (do_fetch) pf_data <= line_buf[rd_addr[AW-1:0]];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sh        <= 2'd0;
      hcnt      <= 2'd0;
      vrep      <= 2'd0;
      in_col    <= '0;
      in_row    <= '0;
      rep_col   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      if (xfer) begin
        if (out_col == last_col) begin
          out_col <= '0;
          out_row <= (out_row == last_orow) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end

      if (load_in) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
        hcnt      <= s_m1;
      end else if (load_rep) begin
        out_data  <= pf_data;
        out_valid <= 1'b1;
        hcnt      <= s_m1;
      end else if (xfer) begin
        if (hcnt != 2'd0) hcnt <= hcnt - 1'b1;
        else              out_valid <= 1'b0;
      end

      if (load_rep) rep_col <= rep_col + 1'b1;

      case (state)
        IDLE: begin
          if (in_valid) begin
            case (scale_sel)
              2'b00:   sh <= 2'd0;
              2'b10:   sh <= 2'd2;
              default: sh <= 2'd1;
            endcase
            state <= FILL;
          end
        end
        FILL, REPEAT: begin
          if (row_end) begin
            if (!copies_done) begin
              vrep    <= vrep + 1'b1;
              rep_col <= '0;
              state   <= REPEAT;
            end else begin
              vrep   <= 2'd0;
              in_col <= '0;
              if (last_in_row) begin
                in_row <= '0;
                state  <= IDLE;
              end else begin
                in_row <= in_row + 1'b1;
                state  <= FILL;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (load_in) in_col <= wr_col + 1'b1;
    end
  end

endmodule
